vga_timing: RTL and testbench

- Raster timing generator for the VGA path, running on the PLL pixel clock.
- Sits directly upstream of the pixel/pattern stage: produces sync, blanking, pixel coordinates and frame/line strobes, and the pattern stage produces RGB from them.
- Defaults give 640x480@60 timing (25.175 MHz nominal pixel clock).
- All outputs are registered and mutually aligned, so the downstream stage can register RGB once and stay in step with sync.

---
 rtl/vga_timing.sv | 73 +++++++
 tb/tb_vga_timing.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator producing sync, blanking, coordinates and line/frame strobes.
// Every output is registered from the same counter snapshot, so all outputs share one cycle of latency.
module vga_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_width_check
        $error("vga_timing: H_TOTAL/V_TOTAL exceed 10-bit counter range");
    end

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_wrap;
    int         hc;
    int         vc;

    assign hc     = int'(h_cnt);
    assign vc     = int'(v_cnt);
    assign h_wrap = hc == H_TOTAL - 1;
    assign v_wrap = vc == V_TOTAL - 1;

    // vsync decodes v_cnt, which only moves on the h wrap, so it toggles as x returns to 0
    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            active      <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_wrap ? '0 : h_cnt + 10'd1;
            if (h_wrap)
                v_cnt   <= v_wrap ? '0 : v_cnt + 10'd1;
            x           <= h_cnt;
            y           <= v_cnt;
            active      <= (hc < H_ACTIVE) && (vc < V_ACTIVE);
            hsync       <= (hc >= HS_BEG && hc < HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync       <= (vc >= VS_BEG && vc < VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
            line_start  <= h_cnt == '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: three geometries (default, tiny with inverted polarity, mid-size) checked every cycle
// against a position-from-cycle-count model, plus hand-computed timing literals.
module tb_vga_timing;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst;
    logic [2:0]       hs, vs, ac, ls, fs;
    logic [2:0][9:0]  xs, ys;

    int n_chk = 0;
    int n_fail = 0;

    // geometry per instance: H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP
    int g[3][8] = '{'{640, 16, 96, 48, 480, 10, 2, 33},
                    '{8, 2, 3, 3, 4, 1, 1, 2},
                    '{64, 16, 24, 16, 48, 10, 2, 33}};
    bit pol[3] = '{1'b0, 1'b1, 1'b0};

    vga_timing u0 (.clock(clk), .reset(rst[0]), .hsync(hs[0]), .vsync(vs[0]), .active(ac[0]),
                   .x(xs[0]), .y(ys[0]), .line_start(ls[0]), .frame_start(fs[0]));

    vga_timing #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
                 .V_BP(2), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1))
        u1 (.clock(clk), .reset(rst[1]), .hsync(hs[1]), .vsync(vs[1]), .active(ac[1]),
            .x(xs[1]), .y(ys[1]), .line_start(ls[1]), .frame_start(fs[1]));

    vga_timing #(.H_ACTIVE(64), .H_FP(16), .H_SYNC(24), .H_BP(16), .V_ACTIVE(48), .V_FP(10),
                 .V_SYNC(2), .V_BP(33))
        u2 (.clock(clk), .reset(rst[2]), .hsync(hs[2]), .vsync(vs[2]), .active(ac[2]),
            .x(xs[2]), .y(ys[2]), .line_start(ls[2]), .frame_start(fs[2]));

    function automatic int htot(int i);
        return g[i][0] + g[i][1] + g[i][2] + g[i][3];
    endfunction

    function automatic int vtot(int i);
        return g[i][4] + g[i][5] + g[i][6] + g[i][7];
    endfunction

    // expected {hsync, vsync, active, line_start, frame_start, x, y} for raster position p
    function automatic logic [24:0] decode(int i, int p);
        int  hx = p % htot(i);
        int  vy = (p / htot(i)) % vtot(i);
        bit  hsa = hx >= g[i][0] + g[i][1] && hx < g[i][0] + g[i][1] + g[i][2];
        bit  vsa = vy >= g[i][4] + g[i][5] && vy < g[i][4] + g[i][5] + g[i][6];
        logic [9:0] xv = 10'(hx);
        logic [9:0] yv = 10'(vy);
        return {hsa ? pol[i] : !pol[i], vsa ? pol[i] : !pol[i], hx < g[i][0] && vy < g[i][4],
                hx == 0, hx == 0 && vy == 0, xv, yv};
    endfunction

    function automatic logic [24:0] rstv(int i);
        return {!pol[i], !pol[i], 23'd0};
    endfunction

    int          pos[3];
    bit          armed[3] = '{1'b0, 1'b0, 1'b0};
    logic [24:0] exp_v[3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                armed[i] = 1'b1;
                pos[i]   = 0;
                exp_v[i] = rstv(i);
            end else if (armed[i]) begin
                exp_v[i] = decode(i, pos[i]);
                pos[i]   = (pos[i] + 1) % (htot(i) * vtot(i));
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (armed[i]) begin
                logic [24:0] act;
                act = {hs[i], vs[i], ac[i], ls[i], fs[i], xs[i], ys[i]};
                n_chk++;
                if (act !== exp_v[i]) begin
                    n_fail++;
                    $display("FAIL model dut%0d: got hs=%b vs=%b act=%b ls=%b fs=%b x=%0d y=%0d, required hs=%b vs=%b act=%b ls=%b fs=%b x=%0d y=%0d",
                             i, act[24], act[23], act[22], act[21], act[20], act[19:10], act[9:0],
                             exp_v[i][24], exp_v[i][23], exp_v[i][22], exp_v[i][21], exp_v[i][20],
                             exp_v[i][19:10], exp_v[i][9:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    initial begin
        int   lp0, lp1, fp1, hlow, hfirst, hlast, acnt, hs1, vs1, per, vlow;
        bit   found;
        logic pv;
        logic [9:0] px, py;
        rst = 3'b111;
        repeat (5) @(negedge clk);
        chk("rst_hsync", int'(hs[0]), 1);
        chk("rst_vsync", int'(vs[0]), 1);
        chk("rst_active", int'(ac[0]), 0);
        chk("rst_x", int'(xs[0]), 0);
        chk("rst_y", int'(ys[0]), 0);
        chk("rst_line_start", int'(ls[0]), 0);
        chk("rst_frame_start", int'(fs[0]), 0);
        chk("rst_hsync_pos_pol", int'(hs[1]), 0);
        rst = 3'b000;
        @(negedge clk);
        chk("rel_x", int'(xs[0]), 0);
        chk("rel_y", int'(ys[0]), 0);
        chk("rel_active", int'(ac[0]), 1);
        chk("rel_line_start", int'(ls[0]), 1);
        chk("rel_frame_start", int'(fs[0]), 1);
        lp0 = 0; lp1 = 0; fp1 = 0; hlow = 0; hfirst = -1; hlast = -1; acnt = 0; hs1 = 0; vs1 = 0;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            if (ls[0] && lp0 == 0) lp0 = k;
            if (ls[1] && lp1 == 0) lp1 = k;
            if (fs[1] && fp1 == 0) fp1 = k;
            if (!hs[0]) begin
                hlow++;
                if (hfirst < 0) hfirst = int'(xs[0]);
                hlast = int'(xs[0]);
            end
            if (ac[0]) acnt++;
            if (k <= 128) begin
                hs1 += int'(hs[1]);
                vs1 += int'(vs[1]);
            end
            if (k == 799) begin
                chk("x_before_wrap", int'(xs[0]), 799);
                chk("y_before_wrap", int'(ys[0]), 0);
            end
        end
        chk("x_after_wrap", int'(xs[0]), 0);
        chk("y_after_wrap", int'(ys[0]), 1);
        chk("line_period", lp0, 800);
        chk("hsync_low_cycles", hlow, 96);
        chk("hsync_first_x", hfirst, 656);
        chk("hsync_last_x", hlast, 751);
        chk("active_cycles", acnt, 640);
        chk("small_line_period", lp1, 16);
        chk("small_frame_period", fp1, 128);
        chk("small_hsync_high", hs1, 24);
        chk("small_vsync_high", vs1, 16);

        found = 1'b0;
        for (int k = 0; k < 12000 && !found; k++) begin
            @(negedge clk);
            found = xs[2] == 10'd90 && ys[2] == 10'd58;
        end
        chk("mid_reached", int'(found), 1);
        chk("mid_pre_hsync", int'(hs[2]), 0);
        chk("mid_pre_vsync", int'(vs[2]), 0);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        chk("mid_rst_hsync", int'(hs[2]), 1);
        chk("mid_rst_vsync", int'(vs[2]), 1);
        chk("mid_rst_x", int'(xs[2]), 0);
        chk("mid_rst_y", int'(ys[2]), 0);
        @(negedge clk);
        chk("mid_restart_fs", int'(fs[2]), 1);

        fork
            begin
                pv = vs[2];
                for (int f = 0; f < 2; f++) begin
                    per = 0; vlow = 0; px = '0; py = '0;
                    for (int k = 1; k <= 11200 && per == 0; k++) begin
                        px = xs[2];
                        py = ys[2];
                        @(negedge clk);
                        if (!vs[2]) vlow++;
                        if (vs[2] != pv) chk("vsync_edge_at_x0", int'(xs[2]), 0);
                        pv = vs[2];
                        if (fs[2]) per = k;
                    end
                    chk("frame_period", per, 11160);
                    chk("vsync_low_cycles", vlow, 240);
                    chk("wrap_prev_x", int'(px), 119);
                    chk("wrap_prev_y", int'(py), 92);
                end
            end
            begin
                repeat (20) begin
                    repeat ($urandom_range(1, 400)) @(negedge clk);
                    rst[1] = 1'b1;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    rst[1] = 1'b0;
                end
            end
        join
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
